reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised synchronous register file for the KURM datapath, successor to the fixed 16x16 file. Provides two registered read ports, one write port, and a per-register busy scoreboard with reserve/release. The scoreboard lets the control unit stall on operands whose producing write is still outstanding. Sits between the decoder (addresses, reserve) and the ALU/writeback stage (C data).

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 16, number of registers (power of two, 2..256)
- AW, 4, address width, equals log2(DEPTH)
- ZERO_R0, 0, when 1 register 0 is hard-wired to zero
- clk  input  1  sole clock; all state updates on rising edge
- clear  input  1  synchronous, active-high reset
- Aaddr  input  AW  read port A address
- Baddr  input  AW  read port B address
- A  output  WIDTH  registered read data, port A
- B  output  WIDTH  registered read data, port B
- A_busy  output  1  registered busy bit of register read on A
- B_busy  output  1  registered busy bit of register read on B
- Caddr  input  AW  write address
- C  input  WIDTH  write data
- load  input  1  write enable; a write also releases busy[Caddr]
- rsv  input  1  reserve request; sets busy[rsv_addr]
- rsv_addr  input  AW  register to reserve
- busy_cnt  output  AW+1  number of registers currently busy

## Operation
- Storage: DEPTH x WIDTH registers, plus a DEPTH-bit busy vector.
- Write: load=1 at a rising edge stores C into reg[Caddr] and clears busy[Caddr].
- Reserve: rsv=1 at a rising edge sets busy[rsv_addr].
- Reserve and write to the same address in one cycle: data is written and busy ends set (reserve wins, new producer).
- Reserve of an already busy register: no change; busy_cnt does not increment.
- Write to a non-busy register: data written; busy_cnt unchanged.
- busy_cnt is maintained incrementally (+1, -1, or 0 per cycle) and always equals popcount(busy). Saturation is impossible because the count is bounded by DEPTH.
- Read: at each edge, A/A_busy capture reg[Aaddr]/busy[Aaddr]; B/B_busy capture likewise from Baddr.
- ZERO_R0=1: writes and reserves to address 0 are ignored; reads of address 0 return 0 with busy 0.
- clear=1: all registers, busy bits, A, B, A_busy, B_busy and busy_cnt go to 0 at the edge. clear overrides load and rsv issued in the same cycle.

## Timing
- Read latency is 1 cycle: address presented before edge N produces data valid after edge N.
- Write is visible in storage after the edge on which load=1.
- Same-cycle read of the address being written is governed by REGFILE_BYPASS_EN (see Configuration).
- A_busy/B_busy reflect busy state after that edge's updates when bypass is enabled. Without bypass they reflect the pre-edge state.
- busy_cnt is updated on the same edge as the busy vector.
- Reset values of all outputs are 0. Clear asserted mid-sequence discards all pending reservations immediately.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches Caddr with load=1 (and not suppressed by ZERO_R0) returns C on that edge. The busy output for that read follows the same-cycle reserve/release result.
- REGFILE_BYPASS_EN undefined: reads return the pre-write storage value and pre-edge busy bit. The written value appears on the next read cycle.

## Test plan
- Reset: clear=1 for 2 cycles, Aaddr=4, Baddr=5 -> A=0, B=0, A_busy=B_busy=0, busy_cnt=0.
- Write/read: load=1, Caddr=4, C=15, then Caddr=5, C=30, with Aaddr=4, Baddr=5 -> after the second edge A=15, B=30. Then load=0, C=50 -> B stays 30.
- Bypass: Aaddr=Caddr=7, C=0x1234, load=1 -> with REGFILE_BYPASS_EN, A=0x1234 on that edge. Without it, A equals the old value, then 0x1234 one cycle later.
- Scoreboard: rsv on 3 then 9 -> busy_cnt=2, Aaddr=3 gives A_busy=1. load Caddr=3 -> busy_cnt=1. rsv=1, rsv_addr=9 with load Caddr=9 in the same cycle -> busy_cnt stays 1, busy[9]=1. A second rsv on 9 -> busy_cnt stays 1.
- ZERO_R0=1: load Caddr=0, C=0xFFFF and rsv_addr=0 -> A at Aaddr=0 reads 0, A_busy=0, busy_cnt unchanged.
- Clear mid-operation: 5 registers reserved and reg2=0xAAAA, then clear=1 with load=1, Caddr=2, C=0x5555 -> busy_cnt=0, reg2 reads 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file: two registered read ports, one write port and a
// per-register busy scoreboard. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [AW-1:0]    Aaddr,
    input  logic [AW-1:0]    Baddr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             A_busy,
    output logic             B_busy,
    input  logic [AW-1:0]    Caddr,
    input  logic [WIDTH-1:0] C,
    input  logic             load,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic [AW:0]      busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             a_busy_q, a_busy_d, b_busy_q, b_busy_d;

    logic wr_en, rs_en, cnt_inc, cnt_dec;

    // Storage, scoreboard and read-port next state
    always_comb begin
        wr_en   = load && !(ZERO_R0 && (Caddr == AW'(0)));
        rs_en   = rsv && !(ZERO_R0 && (rsv_addr == AW'(0)));

        mem_d = mem_q;
        if (wr_en) mem_d[Caddr] = C;

        // Reserve is applied after release so a same-address pair leaves the register busy
        busy_d = busy_q;
        if (wr_en) busy_d[Caddr]    = 1'b0;
        if (rs_en) busy_d[rsv_addr] = 1'b1;

        cnt_inc = rs_en && !busy_q[rsv_addr];
        cnt_dec = wr_en && busy_q[Caddr] && !(rs_en && (rsv_addr == Caddr));
        cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);

`ifdef REGFILE_BYPASS_EN
        a_d      = (wr_en && (Aaddr == Caddr)) ? C : mem_q[Aaddr];
        b_d      = (wr_en && (Baddr == Caddr)) ? C : mem_q[Baddr];
        a_busy_d = busy_d[Aaddr];
        b_busy_d = busy_d[Baddr];
`else
        a_d      = mem_q[Aaddr];
        b_d      = mem_q[Baddr];
        a_busy_d = busy_q[Aaddr];
        b_busy_d = busy_q[Baddr];
`endif
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            busy_q   <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_busy_q <= 1'b0;
            b_busy_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_busy_q <= a_busy_d;
            b_busy_q <= b_busy_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign A_busy   = a_busy_q;
    assign B_busy   = b_busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: vector table plus hand sequences for fill,
// bypass and ZERO_R0 behaviour (second instance with ZERO_R0=1).
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        clear, load, rsv;
    logic [3:0]  Aaddr, Baddr, Caddr, rsv_addr;
    logic [15:0] C;
    logic [15:0] A, B, za, zb;
    logic        A_busy, B_busy, za_busy, zb_busy;
    logic [4:0]  busy_cnt, z_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .clear(clear), .Aaddr(Aaddr), .Baddr(Baddr),
        .A(A), .B(B), .A_busy(A_busy), .B_busy(B_busy),
        .Caddr(Caddr), .C(C), .load(load), .rsv(rsv), .rsv_addr(rsv_addr),
        .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.ZERO_R0(1'b1)) dut_z (
        .clk(clk), .clear(clear), .Aaddr(Aaddr), .Baddr(Baddr),
        .A(za), .B(zb), .A_busy(za_busy), .B_busy(zb_busy),
        .Caddr(Caddr), .C(C), .load(load), .rsv(rsv), .rsv_addr(rsv_addr),
        .busy_cnt(z_cnt)
    );

    typedef struct {
        int clr; int ld; int caddr; int c; int rs; int raddr; int aa; int ba;
        int ea; int eb; int eab; int ebb; int ecnt;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input int clr, input int ld, input int caddr, input int c,
                         input int rs, input int raddr, input int aa, input int ba);
        clear    = (clr != 0);
        load     = (ld != 0);
        Caddr    = 4'(caddr);
        C        = 16'(c);
        rsv      = (rs != 0);
        rsv_addr = 4'(raddr);
        Aaddr    = 4'(aa);
        Baddr    = 4'(ba);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            clr ld ca  c        rs ra aa ba  ea       eb       eab ebb cnt
        tbl[0]  = '{1, 0, 0, 0,       0, 0, 4, 5,  0,       0,       0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,       0, 0, 4, 5,  0,       0,       0, 0, 0};
        tbl[2]  = '{0, 1, 4, 15,      0, 0, 1, 2,  0,       0,       0, 0, 0};
        tbl[3]  = '{0, 1, 5, 30,      0, 0, 4, 1,  15,      0,       0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,       0, 0, 4, 5,  15,      30,      0, 0, 0};
        tbl[5]  = '{0, 0, 5, 50,      0, 0, 4, 5,  15,      30,      0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,       1, 3, 4, 5,  15,      30,      0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0,       1, 9, 3, 4,  0,       15,      1, 0, 2};
        tbl[8]  = '{0, 1, 3, 'h33,    0, 0, 9, 5,  0,       30,      1, 0, 1};
        tbl[9]  = '{0, 1, 9, 'h99,    1, 9, 3, 4,  'h33,    15,      0, 0, 1};
        tbl[10] = '{0, 0, 0, 0,       1, 9, 9, 3,  'h99,    'h33,    1, 0, 1};
        tbl[11] = '{0, 1, 10, 'hAA,   0, 0, 9, 3,  'h99,    'h33,    1, 0, 1};
        tbl[12] = '{0, 0, 0, 0,       0, 0, 10, 9, 'hAA,    'h99,    0, 1, 1};
        tbl[13] = '{0, 1, 2, 'hAAAA,  1, 1, 10, 0, 'hAA,    0,       0, 0, 2};
        tbl[14] = '{0, 0, 0, 0,       1, 2, 1, 9,  0,       'h99,    1, 1, 3};
        tbl[15] = '{0, 0, 0, 0,       1, 3, 2, 5,  'hAAAA,  30,      1, 0, 4};
        tbl[16] = '{0, 0, 0, 0,       1, 4, 9, 2,  'h99,    'hAAAA,  1, 1, 5};
        tbl[17] = '{1, 1, 2, 'h5555,  1, 6, 2, 9,  0,       0,       0, 0, 0};
        tbl[18] = '{0, 0, 0, 0,       0, 0, 2, 4,  0,       0,       0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].clr, tbl[i].ld, tbl[i].caddr, tbl[i].c,
                  tbl[i].rs, tbl[i].raddr, tbl[i].aa, tbl[i].ba);
            check($sformatf("vec%0d A", i),        int'(A),        tbl[i].ea);
            check($sformatf("vec%0d B", i),        int'(B),        tbl[i].eb);
            check($sformatf("vec%0d A_busy", i),   int'(A_busy),   tbl[i].eab);
            check($sformatf("vec%0d B_busy", i),   int'(B_busy),   tbl[i].ebb);
            check($sformatf("vec%0d busy_cnt", i), int'(busy_cnt), tbl[i].ecnt);
        end

        // Reserve every register, then release them all
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 1, i, 0, 0);
            check($sformatf("fill cnt %0d", i), int'(busy_cnt), i + 1);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, i, 0, 0, 0, 0);
            check($sformatf("drain cnt %0d", i), int'(busy_cnt), 15 - i);
        end
        drive(0, 0, 0, 0, 0, 0, 15, 14);
        check("drain A", int'(A), 15);
        check("drain B", int'(B), 14);

        // Same-cycle read of the register being written or reserved
        drive(0, 1, 7, 'h0BAD, 0, 0, 1, 1);
        drive(0, 1, 7, 'h1234, 0, 0, 7, 1);
`ifdef REGFILE_BYPASS_EN
        check("bypass A", int'(A), 'h1234);
`else
        check("bypass A", int'(A), 'h0BAD);
`endif
        drive(0, 0, 0, 0, 0, 0, 7, 1);
        check("bypass A next", int'(A), 'h1234);
        drive(0, 0, 0, 0, 1, 7, 7, 1);
`ifdef REGFILE_BYPASS_EN
        check("bypass rsv busy", int'(A_busy), 1);
`else
        check("bypass rsv busy", int'(A_busy), 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 7, 1);
        check("rsv busy next", int'(A_busy), 1);
        drive(0, 1, 7, 5, 0, 0, 7, 1);
`ifdef REGFILE_BYPASS_EN
        check("bypass rel busy", int'(A_busy), 0);
`else
        check("bypass rel busy", int'(A_busy), 1);
`endif
        check("bypass rel cnt", int'(busy_cnt), 0);

        // Register 0 writes and reserves are ignored only with ZERO_R0=1
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        drive(0, 1, 0, 'hFFFF, 1, 0, 0, 3);
        check("z A", int'(za), 0);
        check("z A_busy", int'(za_busy), 0);
        check("z B_busy", int'(zb_busy), 1);
        check("z cnt", int'(z_cnt), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 3);
        check("z A next", int'(za), 0);
        check("z A_busy next", int'(za_busy), 0);
        check("z cnt next", int'(z_cnt), 1);
        check("r0 A", int'(A), 'hFFFF);
        check("r0 A_busy", int'(A_busy), 1);
        check("r0 cnt", int'(busy_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
